// File: rtl/load_align_unit.sv
// Load-data aligner: extracts a byte, half, word or dword from a big-endian memory word,
// straddling into a second beat when needed, with optional byte reversal and sign extension.
module load_align_unit #(
    parameter  int DATA_WIDTH = 32,
    localparam int NB         = DATA_WIDTH / 8,
    localparam int OFS_W      = $clog2(NB)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [OFS_W-1:0]      req_offset,
    input  logic [1:0]            req_size,
    input  logic                  req_sign,
    input  logic                  req_reverse,
    output logic                  mem_req,
    output logic                  mem_second,
    input  logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FIRST,
        S_SECOND,
        S_DONE
    } state_e;

    state_e                state_q, state_d;
    logic [OFS_W-1:0]      ofs_q, ofs_d;
    logic [1:0]            size_q, size_d;
    logic                  sign_q, sign_d;
    logic                  rev_q, rev_d;
    logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
    logic [DATA_WIDTH-1:0] hold1_q, hold1_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_err_q, out_err_d;
    logic                  split;
    logic                  illegal;

    // Byte k of the field is byte (ofs+k) of c, counted from the MSB end.
    function automatic logic [DATA_WIDTH-1:0] extract(
        input logic [2*DATA_WIDTH-1:0] c,
        input logic [OFS_W-1:0]        ofs,
        input logic [1:0]              size,
        input logic                    sgn,
        input logic                    rev
    );
        logic [DATA_WIDTH-1:0]   r;
        logic [2*DATA_WIDTH-1:0] sh;
        int                      nbytes;
        int                      pos;
        logic                    msb;
        r      = '0;
        nbytes = 1 << size;
        for (int k = 0; k < NB; k++) begin
            if (k < nbytes) begin
                sh  = c << ((int'(ofs) + k) * 8);
                pos = rev ? k : (nbytes - 1 - k);
                r[pos*8 +: 8] = sh[2*DATA_WIDTH-1 -: 8];
            end
        end
        msb = r[nbytes*8-1];
        for (int j = 0; j < DATA_WIDTH; j++) begin
            if (j >= nbytes * 8) r[j] = sgn & msb;
        end
        return r;
    endfunction

    assign split   = (int'(ofs_q) + (1 << size_q)) > NB;
    assign illegal = (1 << req_size) > NB;

    always_comb begin
        state_d    = state_q;
        ofs_d      = ofs_q;
        size_d     = size_q;
        sign_d     = sign_q;
        rev_d      = rev_q;
        hold0_d    = hold0_q;
        hold1_d    = hold1_q;
        out_data_d = out_data_q;
        out_err_d  = out_err_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid) begin
                        ofs_d  = req_offset;
                        size_d = req_size;
                        sign_d = req_sign;
                        rev_d  = req_reverse;
                        if (illegal) begin
                            state_d    = S_DONE;
                            out_err_d  = 1'b1;
                            out_data_d = '0;
                        end else begin
                            state_d   = S_FIRST;
                            out_err_d = 1'b0;
                        end
                    end
                end
                S_FIRST: begin
                    if (mem_valid) begin
                        hold0_d = mem_data;
                        if (split) begin
                            state_d = S_SECOND;
                        end else begin
                            hold1_d    = '0;
                            state_d    = S_DONE;
                            out_data_d = extract({mem_data, {DATA_WIDTH{1'b0}}},
                                                 ofs_q, size_q, sign_q, rev_q);
                        end
                    end
                end
                S_SECOND: begin
                    if (mem_valid) begin
                        hold1_d    = mem_data;
                        state_d    = S_DONE;
                        out_data_d = extract({hold0_q, mem_data}, ofs_q, size_q, sign_q, rev_q);
                    end
                end
                S_DONE: begin
                    if (out_ready) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            ofs_q      <= '0;
            size_q     <= '0;
            sign_q     <= 1'b0;
            rev_q      <= 1'b0;
            hold0_q    <= '0;
            hold1_q    <= '0;
            out_data_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ofs_q      <= ofs_d;
            size_q     <= size_d;
            sign_q     <= sign_d;
            rev_q      <= rev_d;
            hold0_q    <= hold0_d;
            hold1_q    <= hold1_d;
            out_data_q <= out_data_d;
            out_err_q  <= out_err_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign mem_req    = (state_q == S_FIRST) || (state_q == S_SECOND);
    assign mem_second = (state_q == S_SECOND);
    assign out_valid  = (state_q == S_DONE);
    assign out_data   = out_data_q;
    assign out_err    = out_err_q;

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit: one 32-bit and one 64-bit instance sharing stimulus,
// selected by sel64, with hand-computed expected results.
module tb_load_align_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, flush, req_valid, sel64, req_sign, req_reverse, mem_valid, out_ready;
    logic [2:0]  req_offset;
    logic [1:0]  req_size;
    logic [63:0] mem_data;
    logic        rv32, rv64;

    logic        req_ready32, mem_req32, mem_second32, out_valid32, out_err32;
    logic [31:0] out_data32;
    logic        req_ready64, mem_req64, mem_second64, out_valid64, out_err64;
    logic [63:0] out_data64;

    logic        c_ready, c_mreq, c_msec, c_valid, c_err;
    logic [63:0] c_data;

    int nchk = 0;
    int nerr = 0;

    assign rv32 = req_valid & ~sel64;
    assign rv64 = req_valid & sel64;

    load_align_unit #(.DATA_WIDTH(32)) dut32 (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(rv32), .req_ready(req_ready32), .req_offset(req_offset[1:0]),
        .req_size(req_size), .req_sign(req_sign), .req_reverse(req_reverse),
        .mem_req(mem_req32), .mem_second(mem_second32), .mem_valid(mem_valid),
        .mem_data(mem_data[31:0]), .out_valid(out_valid32), .out_ready(out_ready),
        .out_data(out_data32), .out_err(out_err32)
    );

    load_align_unit #(.DATA_WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .flush(flush),
        .req_valid(rv64), .req_ready(req_ready64), .req_offset(req_offset),
        .req_size(req_size), .req_sign(req_sign), .req_reverse(req_reverse),
        .mem_req(mem_req64), .mem_second(mem_second64), .mem_valid(mem_valid),
        .mem_data(mem_data), .out_valid(out_valid64), .out_ready(out_ready),
        .out_data(out_data64), .out_err(out_err64)
    );

    always_comb begin
        c_ready = sel64 ? req_ready64  : req_ready32;
        c_mreq  = sel64 ? mem_req64    : mem_req32;
        c_msec  = sel64 ? mem_second64 : mem_second32;
        c_valid = sel64 ? out_valid64  : out_valid32;
        c_err   = sel64 ? out_err64    : out_err32;
        c_data  = sel64 ? out_data64   : {32'h0, out_data32};
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic s64, input logic [2:0] ofs,
                           input logic [1:0] sz, input logic sg, input logic rv,
                           input logic [63:0] b0, input logic [63:0] b1,
                           input int nwait, input int hold,
                           input logic [63:0] exp_data, input logic exp_err,
                           input int exp_lat, input int exp_nreq, input int exp_nsec);
        int   lat, nreq, nsec, w;
        logic done, firstsec;
        logic [63:0] d0;
        logic        e0;
        @(negedge clk);
        sel64 = s64; req_offset = ofs; req_size = sz; req_sign = sg; req_reverse = rv;
        req_valid = 1'b1; mem_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1; nreq = 0; nsec = 0; w = 0; done = 1'b0; firstsec = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            if (c_valid) begin
                done = 1'b1;
            end else begin
                mem_valid = 1'b0;
                if (c_mreq) begin
                    if (nreq == 0) firstsec = c_msec;
                    nreq++;
                    if (c_msec) nsec++;
                    if (w < nwait) begin
                        w++;
                    end else begin
                        mem_valid = 1'b1;
                        mem_data  = c_msec ? b1 : b0;
                    end
                end
                @(posedge clk);
                @(negedge clk);
                mem_valid = 1'b0;
                lat++;
            end
        end
        check({tag, "_valid"}, {63'h0, done}, 64'h1);
        check({tag, "_data"}, c_data, exp_data);
        check({tag, "_err"}, {63'h0, c_err}, {63'h0, exp_err});
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_nreq"}, 64'(nreq), 64'(exp_nreq));
        check({tag, "_nsec"}, 64'(nsec), 64'(exp_nsec));
        check({tag, "_firstsec"}, {63'h0, firstsec}, 64'h0);
        d0 = c_data;
        e0 = c_err;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            @(negedge clk);
            check({tag, "_bp_data"}, c_data, d0);
            check({tag, "_bp_err"}, {63'h0, c_err}, {63'h0, e0});
            check({tag, "_bp_valid"}, {63'h0, c_valid}, 64'h1);
            check({tag, "_bp_ready"}, {63'h0, c_ready}, 64'h0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_drop_valid"}, {63'h0, c_valid}, 64'h0);
        check({tag, "_idle_ready"}, {63'h0, c_ready}, 64'h1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, {63'h0, c_ready}, 64'h1);
        check({tag, "_mreq"}, {63'h0, c_mreq}, 64'h0);
        check({tag, "_msec"}, {63'h0, c_msec}, 64'h0);
        check({tag, "_valid"}, {63'h0, c_valid}, 64'h0);
        check({tag, "_err"}, {63'h0, c_err}, 64'h0);
        check({tag, "_data"}, c_data, 64'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; flush = 1'b0; req_valid = 1'b0; sel64 = 1'b0;
        req_sign = 1'b0; req_reverse = 1'b0; mem_valid = 1'b0; out_ready = 1'b0;
        req_offset = '0; req_size = '0; mem_data = '0;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst32");
        sel64 = 1'b1;
        #1;
        check_reset_outputs("rst64");
        @(negedge clk);
        reset = 1'b1;
        sel64 = 1'b0;

        //       tag       s64   ofs   sz     sg    rv    beat0                  beat1                  nw hold exp_data               err  lat nreq nsec
        do_load("word0",   1'b0, 3'd0, 2'd2,  1'b0, 1'b0, 64'h11223344,          64'h0,                 0, 0, 64'h11223344,          1'b0, 2, 1, 0);
        do_load("bytes",   1'b0, 3'd2, 2'd0,  1'b1, 1'b0, 64'h1122F344,          64'h0,                 0, 0, 64'hFFFFFFF3,          1'b0, 2, 1, 0);
        do_load("byteu",   1'b0, 3'd2, 2'd0,  1'b0, 1'b0, 64'h1122F344,          64'h0,                 0, 0, 64'h000000F3,          1'b0, 2, 1, 0);
        do_load("halfs",   1'b0, 3'd2, 2'd1,  1'b1, 1'b0, 64'h1122F344,          64'h0,                 0, 0, 64'hFFFFF344,          1'b0, 2, 1, 0);
        do_load("splith",  1'b0, 3'd3, 2'd1,  1'b0, 1'b0, 64'hAABBCCDD,          64'hEEFF0011,          0, 0, 64'h0000DDEE,          1'b0, 3, 2, 1);
        do_load("revw",    1'b0, 3'd0, 2'd2,  1'b0, 1'b1, 64'h11223344,          64'h0,                 0, 0, 64'h44332211,          1'b0, 2, 1, 0);
        do_load("revh",    1'b0, 3'd0, 2'd1,  1'b1, 1'b1, 64'h01800000,          64'h0,                 0, 0, 64'hFFFF8001,          1'b0, 2, 1, 0);
        do_load("illegal", 1'b0, 3'd0, 2'd3,  1'b0, 1'b0, 64'h11223344,          64'h0,                 0, 0, 64'h0,                 1'b1, 1, 0, 0);
        do_load("bpress",  1'b0, 3'd1, 2'd1,  1'b0, 1'b0, 64'h11223344,          64'h0,                 0, 3, 64'h00002233,          1'b0, 2, 1, 0);
        do_load("wait1",   1'b0, 3'd0, 2'd2,  1'b0, 1'b0, 64'hCAFEF00D,          64'h0,                 1, 0, 64'hCAFEF00D,          1'b0, 3, 2, 0);
        do_load("split64", 1'b1, 3'd6, 2'd2,  1'b1, 1'b0, 64'h0011223344556677,  64'h8899AABBCCDDEEFF,  0, 0, 64'h0000000066778899,  1'b0, 3, 2, 1);
        do_load("dword64", 1'b1, 3'd0, 2'd3,  1'b1, 1'b0, 64'hFEDCBA9876543210,  64'h0,                 0, 0, 64'hFEDCBA9876543210,  1'b0, 2, 1, 0);
        do_load("byte64",  1'b1, 3'd7, 2'd0,  1'b1, 1'b0, 64'h0011223344556677,  64'h0,                 0, 0, 64'h0000000000000077,  1'b0, 2, 1, 0);
        do_load("revd64",  1'b1, 3'd5, 2'd3,  1'b0, 1'b1, 64'h0011223344556677,  64'h8899AABBCCDDEEFF,  0, 0, 64'hCCBBAA9988776655,  1'b0, 3, 2, 1);

        // Reset while the 32-bit unit waits on its second beat; out_data is nonzero beforehand.
        do_load("presr",   1'b0, 3'd0, 2'd2,  1'b0, 1'b0, 64'h5A5A5A5A,          64'h0,                 0, 0, 64'h5A5A5A5A,          1'b0, 2, 1, 0);
        @(negedge clk);
        sel64 = 1'b0; req_offset = 3'd2; req_size = 2'd2; req_sign = 1'b0; req_reverse = 1'b0;
        req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        mem_valid = 1'b1; mem_data = 64'h12345678;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0;
        check("rsec_insecond", {63'h0, c_msec}, 64'h1);
        reset = 1'b0;
        #1;
        check_reset_outputs("rsec");
        @(negedge clk);
        reset = 1'b1;

        // Flush in FIRST with a beat arriving the same cycle.
        @(negedge clk);
        req_offset = 3'd0; req_size = 2'd2; req_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("fl_infirst", {63'h0, c_mreq}, 64'h1);
        mem_valid = 1'b1; mem_data = 64'h99887766; flush = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_valid = 1'b0; flush = 1'b0;
        check("fl_ready", {63'h0, c_ready}, 64'h1);
        check("fl_valid", {63'h0, c_valid}, 64'h0);
        check("fl_mreq", {63'h0, c_mreq}, 64'h0);
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            check("fl_novalid", {63'h0, c_valid}, 64'h0);
        end
        do_load("postfl",  1'b0, 3'd1, 2'd0,  1'b1, 1'b0, 64'h00800000,          64'h0,                 0, 0, 64'hFFFFFF80,          1'b0, 2, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/load_align_unit.md
# load_align_unit

Parametrised load-data aligner between the data-memory read port and the register-file writeback. It extracts a byte, halfword, word or doubleword from a big-endian memory word. It supports accesses that straddle a word boundary by fetching two consecutive beats, and applies optional byte reversal and sign extension. Requests and results use valid/ready handshakes, and one load is in flight at a time.

## Interface
Parameters:
- DATA_WIDTH, 32: memory word width in bits. Legal values are 32 and 64.
- NB (localparam), DATA_WIDTH/8: bytes per word.
- OFS_W (localparam), $clog2(NB): byte-offset width.

Ports:
- clk  in  1  clock. One clock; all state is updated on its rising edge.
- reset  in  1  reset, asynchronous and active-low.
- flush  in  1  synchronous abort of the current load.
- req_valid  in  1  load request valid.
- req_ready  out  1  high only in IDLE.
- req_offset  in  OFS_W  byte offset within the word. Byte 0 is bits [DATA_WIDTH-1 -: 8].
- req_size  in  2  access size in bytes is 1<<req_size: 0=byte, 1=half, 2=word, 3=dword.
- req_sign  in  1  sign-extend the result.
- req_reverse  in  1  byte-reverse the extracted field.
- mem_req  out  1  beat request; high in FIRST and SECOND.
- mem_second  out  1  high in SECOND; the beat requested is at word address +1.
- mem_valid  in  1  beat data valid; sampled only while mem_req=1.
- mem_data  in  DATA_WIDTH  beat data.
- out_valid  out  1  result valid; high in DONE.
- out_ready  in  1  consumer accepts the result.
- out_data  out  DATA_WIDTH  aligned, right-justified result.
- out_err  out  1  illegal size: 1<<req_size > NB.

## Operation
- Request handling:
  - The FSM has four states: IDLE, FIRST, SECOND, DONE.
  - A request is accepted when req_valid & req_ready. Offset, size, sign and reverse are latched.
- Transitions out of IDLE on accept:
  - Illegal size → DONE, with out_err=1 and out_data=0. No mem_req is issued.
  - Otherwise → FIRST.
- FIRST:
  - On mem_valid, mem_data is captured into hold0.
  - The access is split when offset + (1<<size) > NB. A split access goes → SECOND; otherwise → DONE.
- SECOND: on mem_valid, mem_data is captured into hold1, then → DONE.
- DONE:
  - out_valid=1.
  - On out_ready → IDLE. A new request is not accepted in the same cycle.
- Extraction, computed when entering DONE and registered into out_data:
  - Form C = {hold0, hold1}, 2·DATA_WIDTH bits. hold1 is 0 when the access is not split.
  - Select bytes offset … offset+(1<<size)-1 of C in big-endian order. Place the field in the low bits of out_data.
  - If req_reverse, reverse the byte order of the field. This has no effect for size 0.
  - Upper bits are filled with the field MSB if req_sign, otherwise with 0. A field that fills the whole word is unchanged.
- flush:
  - In any state, the next state is IDLE and out_valid drops.
  - A mem_valid arriving in the same cycle is discarded.
  - flush has priority over all other events.
- Reset: asynchronous. State → IDLE; out_data, out_err, hold0, hold1 and all latched fields → 0.

## Timing
- Reset values:
  - req_ready=1.
  - mem_req, mem_second, out_valid, out_err = 0.
  - out_data=0.
- mem_req and mem_second are combinational from state. out_data and out_err are registered and stable while out_valid=1.
- mem_valid may be asserted in the same cycle as mem_req (zero-wait memory).
- Latency from the accept edge to out_valid, with zero-wait memory:
  - aligned: 2 cycles.
  - split: 3 cycles.
  - illegal size: 1 cycle.
  - Each memory wait cycle adds 1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_err stay stable and req_ready stays 0.
- Throughput: at most one load per 3 cycles for aligned accesses (IDLE, FIRST, DONE).

## Test plan
- DATA_WIDTH=32, aligned load, offset 0, size 2, mem_data 0x11223344 (mem_valid in the mem_req cycle):
  - out_data=0x11223344.
  - out_valid 2 cycles after accept.
  - Exactly one mem_req cycle, mem_second=0.
- Byte load, offset 2, size 0, mem_data 0x1122F344:
  - sign=1 → 0xFFFFFFF3.
  - sign=0 → 0x000000F3.
- Split halfword, offset 3, size 1, beats 0xAABBCCDD then 0xEEFF0011:
  - out_data=0x0000DDEE.
  - mem_second=1 only on the second beat.
  - Latency 3 cycles.
- DATA_WIDTH=64, split word, offset 6, size 2, beats 0x0011223344556677 then 0x8899AABBCCDDEEFF:
  - sign=1 → 0x000000006677_8899 zero-upper.
  - Because sign is set and the MSB of 0x66778899 is 0, out_data=0x0000000066778899.
- Byte reversal:
  - Word, offset 0, reverse=1, data 0x11223344 → 0x44332211.
  - Halfword, offset 0, reverse=1, sign=1, data 0x0180_0000 → 0xFFFF8001.
- Error, backpressure and abort:
  - DATA_WIDTH=32, size 3 → out_err=1, out_data=0, no mem_req, out_valid 1 cycle after accept.
  - out_ready held low 3 cycles → outputs stable, req_ready=0.
  - reset asserted in SECOND → all outputs return to reset values immediately.
  - flush in FIRST with mem_valid=1 → IDLE next cycle, no out_valid.
